// File: rtl/bram_stimulus_gen_if.sv
// Bundles the run-control inputs and the generated BRAM-port/status outputs
// of the stimulus generator. master = generator side, slave = consumer side.
interface bram_stimulus_gen_if #(
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 64,
    parameter int WEWIDTH   = 4,
    parameter int LEN_WIDTH = 16
);
    logic                 start;
    logic [1:0]           mode;
    logic [AWIDTH-1:0]    base_addr;
    logic [LEN_WIDTH-1:0] len;
    logic                 stall;

    logic [AWIDTH-1:0]    bram_addr_ext;
    logic [DWIDTH-1:0]    bram_wdata_ext;
    logic [WEWIDTH-1:0]   bram_we_ext;
    logic                 op_valid;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [LEN_WIDTH:0]   op_count;

    modport master (
        input  start, mode, base_addr, len, stall,
        output bram_addr_ext, bram_wdata_ext, bram_we_ext,
        output op_valid, busy, done, err, op_count
    );

    modport slave (
        output start, mode, base_addr, len, stall,
        input  bram_addr_ext, bram_wdata_ext, bram_we_ext,
        input  op_valid, busy, done, err, op_count
    );
endinterface

// File: rtl/bram_stimulus_gen.sv
// Mode-programmable pseudo-random BRAM stimulus generator.
//
// state | meaning
// IDLE  | waiting for start; outputs hold, no op
// WR    | phase 1 ops (RANDOM writes, SWEEP writes, READ reads)
// RD    | SWEEP phase 2 reads over the same address range
// FIN   | completion; done pulses for one cycle, then IDLE.
//       | Entered straight from IDLE (len=0 / reserved mode) with done=0,
//       | which spends one busy cycle before the done pulse.
//
// Every output is a register. The LFSRs always hold the value of the op on
// display, so the next op is built from the post-advance LFSR values.
module bram_stimulus_gen #(
    parameter int          AWIDTH    = 10,
    parameter int          DWIDTH    = 64,
    parameter int          WEWIDTH   = 4,
    parameter int          LEN_WIDTH = 16,
    parameter logic [31:0] SEED      = 32'h1
) (
    input logic                 clk,
    input logic                 resetn,
    bram_stimulus_gen_if.master bus
);
    localparam int          NW   = (DWIDTH + 31) / 32;
    localparam logic [31:0] POLY = 32'h80200003;
    localparam logic [1:0]  M_RANDOM = 2'd0;
    localparam logic [1:0]  M_SWEEP  = 2'd1;
    localparam logic [1:0]  M_RSVD   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_FIN} state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] nonzero(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] data_seed(input int k);
        return nonzero(SEED ^ (32'h9E3779B9 * 32'(k + 1)));
    endfunction

    state_t                   state;
    logic [1:0]               mode_q;
    logic [AWIDTH-1:0]        base_q;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [LEN_WIDTH-1:0]     idx;
    logic [31:0]              addr_lfsr;
    logic [31:0]              we_lfsr;
    logic [NW-1:0][31:0]      data_lfsr;

    logic [AWIDTH-1:0]        addr_q;
    logic [DWIDTH-1:0]        wdata_q;
    logic [WEWIDTH-1:0]       we_q;
    logic                     op_valid_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;
    logic [LEN_WIDTH:0]       op_count_q;

    logic                     accept;
    logic                     last;
    logic [31:0]              addr_lfsr_nxt;
    logic [31:0]              we_lfsr_nxt;
    logic [NW-1:0][31:0]      data_lfsr_nxt;
    logic [NW*32-1:0]         data_flat;
    logic [1:0]               nop_mode;
    logic                     nop_rd;
    logic [AWIDTH-1:0]        nop_base;
    logic [LEN_WIDTH-1:0]     nop_idx;
    logic [AWIDTH-1:0]        nop_addr;
    logic [WEWIDTH-1:0]       nop_we;
    logic [DWIDTH-1:0]        nop_wdata;

    // LFSR advance on acceptance and description of the op to show next
    always_comb begin
        accept = op_valid_q & ~bus.stall;
        last   = (idx + LEN_WIDTH'(1)) == len_q;

        addr_lfsr_nxt = addr_lfsr;
        we_lfsr_nxt   = we_lfsr;
        data_lfsr_nxt = data_lfsr;
        if (accept && state == S_WR && mode_q == M_RANDOM) begin
            addr_lfsr_nxt = lfsr_step(addr_lfsr);
            we_lfsr_nxt   = lfsr_step(we_lfsr);
        end
        if (accept && state == S_WR && (mode_q == M_RANDOM || mode_q == M_SWEEP)) begin
            for (int k = 0; k < NW; k++) begin
                data_lfsr_nxt[k] = lfsr_step(data_lfsr[k]);
            end
        end
        data_flat = data_lfsr_nxt;

        if (state == S_IDLE) begin
            nop_mode = bus.mode;
            nop_base = bus.base_addr;
            nop_rd   = 1'b0;
            nop_idx  = '0;
        end else begin
            nop_mode = mode_q;
            nop_base = base_q;
            nop_rd   = (state == S_RD) || last;
            nop_idx  = last ? '0 : idx + LEN_WIDTH'(1);
        end

        nop_addr  = nop_base + AWIDTH'(nop_idx);
        nop_we    = '0;
        nop_wdata = '0;
        if (!nop_rd && nop_mode == M_RANDOM) begin
            nop_addr  = addr_lfsr_nxt[AWIDTH-1:0];
            nop_we    = we_lfsr_nxt[WEWIDTH-1:0];
            nop_wdata = data_flat[DWIDTH-1:0];
        end else if (!nop_rd && nop_mode == M_SWEEP) begin
            nop_we    = '1;
            nop_wdata = data_flat[DWIDTH-1:0];
        end
    end

    // Sequencing FSM, LFSR state and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            mode_q     <= 2'd0;
            base_q     <= '0;
            len_q      <= '0;
            idx        <= '0;
            addr_lfsr  <= nonzero(SEED);
            we_lfsr    <= nonzero(~SEED);
            for (int k = 0; k < NW; k++) begin
                data_lfsr[k] <= data_seed(k);
            end
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            op_count_q <= '0;
        end else begin
            addr_lfsr <= addr_lfsr_nxt;
            we_lfsr   <= we_lfsr_nxt;
            data_lfsr <= data_lfsr_nxt;
            if (accept && op_count_q != '1) begin
                op_count_q <= op_count_q + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mode_q     <= bus.mode;
                        base_q     <= bus.base_addr;
                        len_q      <= bus.len;
                        idx        <= '0;
                        op_count_q <= '0;
                        busy_q     <= 1'b1;
                        err_q      <= (bus.mode == M_RSVD);
                        if (bus.mode == M_RSVD || bus.len == '0) begin
                            state <= S_FIN;
                        end else begin
                            state      <= S_WR;
                            op_valid_q <= 1'b1;
                            addr_q     <= nop_addr;
                            we_q       <= nop_we;
                            wdata_q    <= nop_wdata;
                        end
                    end
                end
                S_WR, S_RD: begin
                    if (accept) begin
                        if (last && !(state == S_WR && mode_q == M_SWEEP)) begin
                            state      <= S_FIN;
                            op_valid_q <= 1'b0;
                            we_q       <= '0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            if (last) begin
                                state <= S_RD;
                            end
                            idx     <= nop_idx;
                            addr_q  <= nop_addr;
                            we_q    <= nop_we;
                            wdata_q <= nop_wdata;
                        end
                    end
                end
                default: begin
                    if (done_q) begin
                        done_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.bram_addr_ext  = addr_q;
    assign bus.bram_wdata_ext = wdata_q;
    assign bus.bram_we_ext    = we_q;
    assign bus.op_valid       = op_valid_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.op_count       = op_count_q;
endmodule

// File: tb/tb_bram_stimulus_gen.sv
// Bench for bram_stimulus_gen: an op-list model predicts every operation of a
// run, a negedge compare process checks the DUT against it each cycle, and
// directed runs pin latencies and a few hand-computed values.
module tb_bram_stimulus_gen;
    localparam int AW = 10;
    localparam int DW = 40;
    localparam int WW = 4;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    bram_stimulus_gen_if #(.AWIDTH(AW), .DWIDTH(DW), .WEWIDTH(WW), .LEN_WIDTH(LW)) bus ();

    bram_stimulus_gen #(
        .AWIDTH(AW), .DWIDTH(DW), .WEWIDTH(WW), .LEN_WIDTH(LW), .SEED(32'h1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [WW-1:0] w;
        logic [DW-1:0] d;
    } op_t;

    op_t         exp_q[$];
    logic [31:0] m_addr, m_we, m_d0, m_d1;
    int          exp_count;
    logic        exp_err;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    int          checks = 0;
    int          errors = 0;

    logic [AW-1:0] rec_a [64];
    logic [WW-1:0] rec_w [64];
    logic [DW-1:0] rec_d [64];
    logic          rec_v [64];
    logic          rec_b [64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    task automatic model_reset();
        m_addr    = 32'h1;
        m_we      = ~32'h1;
        m_d0      = 32'h1 ^ 32'h9E3779B9;
        m_d1      = 32'h1 ^ 32'(32'h9E3779B9 * 2);
        exp_q.delete();
        exp_count = 0;
        exp_err   = 1'b0;
        last_a    = '0;
        last_d    = '0;
    endtask

    // Build the full list of ops a run must produce
    task automatic model_plan(input logic [1:0] mode, input logic [AW-1:0] base, input logic [LW-1:0] len);
        op_t o;
        logic [63:0] cat;
        exp_count = 0;
        exp_err   = (mode == 2'd3);
        if (mode == 2'd3) return;
        for (int i = 0; i < int'(len); i++) begin
            cat = {m_d1, m_d0};
            if (mode == 2'd0) begin
                o.a = m_addr[AW-1:0];
                o.w = m_we[WW-1:0];
                o.d = cat[DW-1:0];
                m_addr = step(m_addr);
                m_we   = step(m_we);
                m_d0   = step(m_d0);
                m_d1   = step(m_d1);
            end else if (mode == 2'd1) begin
                o.a = AW'((int'(base) + i) % (1 << AW));
                o.w = '1;
                o.d = cat[DW-1:0];
                m_d0 = step(m_d0);
                m_d1 = step(m_d1);
            end else begin
                o.a = AW'((int'(base) + i) % (1 << AW));
                o.w = '0;
                o.d = '0;
            end
            exp_q.push_back(o);
        end
        if (mode == 2'd1) begin
            for (int i = 0; i < int'(len); i++) begin
                o.a = AW'((int'(base) + i) % (1 << AW));
                o.w = '0;
                o.d = '0;
                exp_q.push_back(o);
            end
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (resetn) begin
            chk("op_count", 64'(bus.op_count), 64'(exp_count));
            chk("err", 64'(bus.err), 64'(exp_err));
            if (bus.op_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_op: got op_valid=1 expected no op (t=%0t)", $time);
                end else begin
                    chk("addr", 64'(bus.bram_addr_ext), 64'(exp_q[0].a));
                    chk("we", 64'(bus.bram_we_ext), 64'(exp_q[0].w));
                    chk("wdata", 64'(bus.bram_wdata_ext), 64'(exp_q[0].d));
                    last_a = exp_q[0].a;
                    last_d = exp_q[0].d;
                    if (!bus.stall) begin
                        void'(exp_q.pop_front());
                        exp_count++;
                    end
                end
            end else begin
                chk("idle_we", 64'(bus.bram_we_ext), 64'h0);
                chk("hold_addr", 64'(bus.bram_addr_ext), 64'(last_a));
                chk("hold_wdata", 64'(bus.bram_wdata_ext), 64'(last_d));
            end
            if (bus.done) chk("done_queue_empty", 64'(exp_q.size()), 64'h0);
        end
    end

    // One run: start in cycle 0, record cycles 1.., stop at done or abort
    task automatic run(input logic [1:0] mode, input logic [AW-1:0] base, input logic [LW-1:0] len,
                       input logic [15:0] stall_mask, input int busy_start_cyc, input int abort_cyc,
                       output int done_cyc);
        int c;
        done_cyc = -1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.mode = mode;
        bus.base_addr = base;
        bus.len = len;
        bus.stall = stall_mask[0];
        c = 0;
        while (c < 60) begin
            @(posedge clk); #1;
            c++;
            if (c == 1) model_plan(mode, base, len);
            bus.start = (c == busy_start_cyc);
            bus.stall = (c < 16) ? stall_mask[c] : 1'b0;
            rec_a[c] = bus.bram_addr_ext;
            rec_w[c] = bus.bram_we_ext;
            rec_d[c] = bus.bram_wdata_ext;
            rec_v[c] = bus.op_valid;
            rec_b[c] = bus.busy;
            if (c == abort_cyc) begin
                #2 resetn = 1'b0;
                #1;
                chk("rst_addr", 64'(bus.bram_addr_ext), 64'h0);
                chk("rst_we", 64'(bus.bram_we_ext), 64'h0);
                chk("rst_wdata", 64'(bus.bram_wdata_ext), 64'h0);
                chk("rst_valid", 64'(bus.op_valid), 64'h0);
                chk("rst_busy", 64'(bus.busy), 64'h0);
                chk("rst_op_count", 64'(bus.op_count), 64'h0);
                model_reset();
                bus.stall = 1'b0;
                bus.start = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_no_done", 64'(bus.done), 64'h0);
                end
                #2 resetn = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("post_rst_no_done", 64'(bus.done), 64'h0);
                end
                done_cyc = -2;
                return;
            end
            if (bus.done) begin
                done_cyc = c;
                break;
            end
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        if (done_cyc == -1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 60 cycles expected done");
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, dc_a;
        bus.start = 1'b0;
        bus.mode = 2'd0;
        bus.base_addr = '0;
        bus.len = '0;
        bus.stall = 1'b0;
        model_reset();
        #1;
        chk("reset_addr", 64'(bus.bram_addr_ext), 64'h0);
        chk("reset_we", 64'(bus.bram_we_ext), 64'h0);
        chk("reset_wdata", 64'(bus.bram_wdata_ext), 64'h0);
        chk("reset_valid", 64'(bus.op_valid), 64'h0);
        chk("reset_busy", 64'(bus.busy), 64'h0);
        chk("reset_done", 64'(bus.done), 64'h0);
        chk("reset_err", 64'(bus.err), 64'h0);
        chk("reset_op_count", 64'(bus.op_count), 64'h0);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;

        // RANDOM, len=2, from seed
        run(2'd0, '0, 16'd2, 16'h0, 0, 0, dc);
        chk("t1_done_cyc", 64'(dc), 64'd3);
        chk("t1_busy1", 64'(rec_b[1]), 64'h1);
        chk("t1_valid1", 64'(rec_v[1]), 64'h1);
        chk("t1_addr1", 64'(rec_a[1]), 64'h001);
        chk("t1_we1", 64'(rec_w[1]), 64'hE);
        chk("t1_wdata1", 64'(rec_d[1]), 64'h73_9E3779B8);
        chk("t1_addr2", 64'(rec_a[2]), 64'h003);
        chk("t1_we_done", 64'(rec_w[3]), 64'h0);
        chk("t1_op_count", 64'(bus.op_count), 64'd2);

        // SWEEP with address wrap
        run(2'd1, 10'h3FE, 16'd3, 16'h0, 0, 0, dc);
        chk("t2_done_cyc", 64'(dc), 64'd7);
        chk("t2_addr1", 64'(rec_a[1]), 64'h3FE);
        chk("t2_addr3", 64'(rec_a[3]), 64'h000);
        chk("t2_we2", 64'(rec_w[2]), 64'hF);
        chk("t2_addr4", 64'(rec_a[4]), 64'h3FE);
        chk("t2_we4", 64'(rec_w[4]), 64'h0);
        chk("t2_wdata5", 64'(rec_d[5]), 64'h0);
        chk("t2_addr6", 64'(rec_a[6]), 64'h000);
        chk("t2_op_count", 64'(bus.op_count), 64'd6);

        // RANDOM len=4 without and with a 3-cycle stall
        run(2'd0, '0, 16'd4, 16'h0, 0, 0, dc_a);
        chk("t3_done_nostall", 64'(dc_a), 64'd5);
        run(2'd0, '0, 16'd4, 16'b0000_0000_0001_1100, 0, 0, dc);
        chk("t3_done_stall", 64'(dc), 64'd8);
        chk("t3_op_count", 64'(bus.op_count), 64'd4);

        // Empty runs and reserved mode
        run(2'd0, '0, 16'd0, 16'h0, 0, 0, dc);
        chk("t4_len0_done", 64'(dc), 64'd2);
        chk("t4_len0_busy", 64'(rec_b[1]), 64'h1);
        chk("t4_len0_valid", 64'(rec_v[1]), 64'h0);
        chk("t4_len0_count", 64'(bus.op_count), 64'h0);
        run(2'd3, '0, 16'd5, 16'h0, 0, 0, dc);
        chk("t4_rsvd_done", 64'(dc), 64'd2);
        chk("t4_rsvd_err", 64'(bus.err), 64'h1);
        run(2'd2, 10'h100, 16'd2, 16'h0, 0, 0, dc);
        chk("t4_read_done", 64'(dc), 64'd3);
        chk("t4_read_addr1", 64'(rec_a[1]), 64'h100);
        chk("t4_read_we1", 64'(rec_w[1]), 64'h0);
        chk("t4_err_cleared", 64'(bus.err), 64'h0);

        // Reset mid-SWEEP, then rerun reproduces the seeded sequence
        run(2'd1, 10'h010, 16'd4, 16'h0, 0, 3, dc);
        chk("t5_aborted", 64'(dc), 64'(-2));
        run(2'd0, '0, 16'd2, 16'h0, 0, 0, dc);
        chk("t5_done_cyc", 64'(dc), 64'd3);
        chk("t5_addr1", 64'(rec_a[1]), 64'h001);
        chk("t5_we1", 64'(rec_w[1]), 64'hE);
        chk("t5_wdata1", 64'(rec_d[1]), 64'h73_9E3779B8);
        chk("t5_addr2", 64'(rec_a[2]), 64'h003);

        // start pulsed while busy is ignored
        run(2'd0, '0, 16'd3, 16'h0, 2, 0, dc);
        chk("t6_done_cyc", 64'(dc), 64'd4);
        chk("t6_op_count", 64'(bus.op_count), 64'd3);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
